// File: rtl/mmio_hub.sv
// Memory-mapped I/O hub: region decode, instruction-memory passthrough,
// LED register, synchronised switches with sticky edges, prescaled timer.
//
// Ports:
//   Clock, Reset       : system clock, synchronous active-high reset
//   ADDR, DOUT, W      : processor address, write data, write strobe
//   DIN                : read data, valid the cycle after ADDR
//   mem_addr, mem_wren : instruction-memory address / write enable
//   mem_q              : instruction-memory synchronous read data
//   SW_in              : raw asynchronous switches
//   LED_out            : LED register
//   timer_irq          : timer expired flag (level)
module mmio_hub #(
    parameter int MEM_AW   = 8,
    parameter int LED_W    = 9,
    parameter int SW_W     = 9,
    parameter int TIMER_W  = 16,
    parameter int PRESCALE = 1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [15:0]       ADDR,
    input  logic [15:0]       DOUT,
    input  logic              W,
    output logic [15:0]       DIN,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_wren,
    input  logic [15:0]       mem_q,
    input  logic [SW_W-1:0]   SW_in,
    output logic [LED_W-1:0]  LED_out,
    output logic              timer_irq
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

    typedef enum logic [2:0] {
        RG_NONE,
        RG_MEM,
        RG_LED,
        RG_SW,
        RG_TMR
    } region_e;

    region_e              region;
    logic [1:0]           off;

    region_e              sel_d, sel_q;
    logic [15:0]          rdata_d, rdata_q;
    logic [LED_W-1:0]     led_d, led_q;
    logic [SW_W-1:0]      s1_d, s1_q;
    logic [SW_W-1:0]      s2_d, s2_q;
    logic [SW_W-1:0]      s3_d, s3_q;
    logic [SW_W-1:0]      edge_d, edge_q;
    logic [SW_W-1:0]      edge_clr;
    logic [TIMER_W-1:0]   load_d, load_q;
    logic [TIMER_W-1:0]   count_d, count_q;
    logic                 en_d, en_q;
    logic                 auto_d, auto_q;
    logic                 exp_d, exp_q;
    logic [PW-1:0]        presc_d, presc_q;

    logic                 wr_led;
    logic                 wr_edge;
    logic                 wr_load;
    logic                 wr_ctrl;
    logic                 wr_stat;
    logic                 tick;
    logic                 exp_set;

    // Only the decoded bits of the bus are used; the rest are don't-care.
    logic                 unused_bits;
    assign unused_bits = ^{ADDR, DOUT};

    always_comb begin
        region = RG_NONE;
        case (ADDR[15:12])
            4'h0:    region = RG_MEM;
            4'h1:    region = RG_LED;
            4'h3:    region = RG_SW;
            4'h4:    region = RG_TMR;
            default: region = RG_NONE;
        endcase
    end

    assign off      = ADDR[1:0];
    assign mem_addr = ADDR[MEM_AW-1:0];
    assign mem_wren = W & (region == RG_MEM);

    assign wr_led  = W && (region == RG_LED);
    assign wr_edge = W && (region == RG_SW)  && (off == 2'd1);
    assign wr_load = W && (region == RG_TMR) && (off == 2'd0);
    assign wr_ctrl = W && (region == RG_TMR) && (off == 2'd2);
    assign wr_stat = W && (region == RG_TMR) && (off == 2'd3);

    // LED register and switch synchroniser / sticky edge capture
    always_comb begin
        led_d    = wr_led ? DOUT[LED_W-1:0] : led_q;
        s1_d     = SW_in;
        s2_d     = s1_q;
        s3_d     = s2_q;
        edge_clr = wr_edge ? DOUT[SW_W-1:0] : '0;
        // new edges are ORed in after the clear, so a coincident set wins
        edge_d   = (edge_q & ~edge_clr) | (s2_q & ~s3_q);
    end

    assign tick = en_q && (presc_q == PRESC_MAX);

    // Timer: prescaler, down-counter, reload / one-shot, expiry flag
    always_comb begin
        presc_d = presc_q;
        count_d = count_q;
        load_d  = load_q;
        en_d    = en_q;
        auto_d  = auto_q;
        exp_set = 1'b0;

        if (en_q) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end

        if (tick) begin
            if (count_q != '0) begin
                count_d = count_q - TIMER_W'(1);
            end else begin
                exp_set = 1'b1;
                if (auto_q) begin
                    count_d = load_q;
                end else begin
                    en_d = 1'b0;
                end
            end
        end

        // software writes take priority over the tick's effects
        if (wr_ctrl) begin
            en_d   = DOUT[0];
            auto_d = DOUT[1];
        end

        if (wr_load) begin
            load_d  = DOUT[TIMER_W-1:0];
            count_d = DOUT[TIMER_W-1:0];
            presc_d = '0;
        end

        exp_d = (exp_q & ~(wr_stat & DOUT[0])) | exp_set;
    end

    // Read data is captured from pre-edge register values
    always_comb begin
        sel_d   = region;
        rdata_d = '0;
        case (region)
            RG_LED: rdata_d[LED_W-1:0] = led_q;
            RG_SW: begin
                case (off)
                    2'd0:    rdata_d[SW_W-1:0] = s2_q;
                    2'd1:    rdata_d[SW_W-1:0] = edge_q;
                    default: rdata_d = '0;
                endcase
            end
            RG_TMR: begin
                case (off)
                    2'd0:    rdata_d[TIMER_W-1:0] = load_q;
                    2'd1:    rdata_d[TIMER_W-1:0] = count_q;
                    2'd2:    rdata_d[1:0] = {auto_q, en_q};
                    default: rdata_d[0] = exp_q;
                endcase
            end
            default: rdata_d = '0;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            sel_q   <= RG_NONE;
            rdata_q <= '0;
            led_q   <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
            s3_q    <= '0;
            edge_q  <= '0;
            load_q  <= '0;
            count_q <= '0;
            en_q    <= 1'b0;
            auto_q  <= 1'b0;
            exp_q   <= 1'b0;
            presc_q <= '0;
        end else begin
            sel_q   <= sel_d;
            rdata_q <= rdata_d;
            led_q   <= led_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            s3_q    <= s3_d;
            edge_q  <= edge_d;
            load_q  <= load_d;
            count_q <= count_d;
            en_q    <= en_d;
            auto_q  <= auto_d;
            exp_q   <= exp_d;
            presc_q <= presc_d;
        end
    end

    // Memory data arrives from the synchronous RAM in the same cycle
    // that the registered select points at it.
    assign DIN       = (sel_q == RG_MEM) ? mem_q : rdata_q;
    assign LED_out   = led_q;
    assign timer_irq = exp_q;

endmodule

// File: tb/tb_mmio_hub.sv
// Directed bench for mmio_hub: two instances (PRESCALE=1 and 4)
// share the processor bus and switch inputs.
module tb_mmio_hub;

    logic        clk;
    logic        rst;
    logic [15:0] addr;
    logic [15:0] dout;
    logic        w;
    logic [15:0] mem_q;
    logic [8:0]  sw;

    logic [15:0] din1, din4;
    logic [7:0]  maddr1, maddr4;
    logic        mwren1, mwren4;
    logic [8:0]  led1, led4;
    logic        irq1, irq4;

    int n_vec = 0;
    int n_err = 0;

    mmio_hub #(.PRESCALE(1)) u1 (
        .Clock(clk), .Reset(rst), .ADDR(addr), .DOUT(dout), .W(w),
        .DIN(din1), .mem_addr(maddr1), .mem_wren(mwren1),
        .mem_q(mem_q), .SW_in(sw), .LED_out(led1), .timer_irq(irq1)
    );

    mmio_hub #(.PRESCALE(4)) u4 (
        .Clock(clk), .Reset(rst), .ADDR(addr), .DOUT(dout), .W(w),
        .DIN(din4), .mem_addr(maddr4), .mem_wren(mwren4),
        .mem_q(mem_q), .SW_in(sw), .LED_out(led4), .timer_irq(irq4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input logic [15:0] a, input logic [15:0] d,
                       input logic wr);
        addr = a;
        dout = d;
        w    = wr;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst   = 1'b1;
        addr  = 16'h1000;
        dout  = 16'h01FF;
        w     = 1'b1;
        mem_q = 16'h0000;
        sw    = 9'h000;

        // reset with a pending LED write
        cyc(16'h1000, 16'h01FF, 1'b1);
        cyc(16'h1000, 16'h01FF, 1'b1);
        chk("rst_led", {7'd0, led1}, 16'h0000);
        chk("rst_din", din1, 16'h0000);
        chk("rst_irq", {15'd0, irq1}, 16'h0000);
        rst = 1'b0;
        cyc(16'h7000, 16'h0000, 1'b0);
        chk("post_rst_led", {7'd0, led1}, 16'h0000);
        chk("post_rst_din", din1, 16'h0000);

        // LED write then read-back
        cyc(16'h1000, 16'h0155, 1'b1);
        chk("led_out", {7'd0, led1}, 16'h0155);
        chk("led_rd_old", din1, 16'h0000);
        cyc(16'h1000, 16'h0000, 1'b0);
        chk("led_rd", din1, 16'h0155);

        // MEM passthrough
        addr = 16'h0010;
        w    = 1'b1;
        #1;
        chk("mem_wren_w", {15'd0, mwren1}, 16'h0001);
        chk("mem_addr", {8'd0, maddr1}, 16'h0010);
        addr = 16'h1000;
        #1;
        chk("mem_wren_led", {15'd0, mwren1}, 16'h0000);
        mem_q = 16'hBEEF;
        cyc(16'h0005, 16'h0000, 1'b0);
        chk("mem_rd", din1, 16'hBEEF);
        cyc(16'h7000, 16'h0000, 1'b0);
        chk("none_rd", din1, 16'h0000);

        // switch synchroniser latency and edge register
        sw = 9'h005;
        cyc(16'h3000, 16'h0000, 1'b0);
        chk("sw_c1", din1, 16'h0000);
        cyc(16'h3000, 16'h0000, 1'b0);
        chk("sw_c2", din1, 16'h0000);
        cyc(16'h3000, 16'h0000, 1'b0);
        chk("sw_c3", din1, 16'h0005);
        cyc(16'h3001, 16'h0000, 1'b0);
        chk("edge_rd", din1, 16'h0005);
        cyc(16'h3001, 16'h0001, 1'b1);
        cyc(16'h3001, 16'h0000, 1'b0);
        chk("edge_w1c", din1, 16'h0004);
        cyc(16'h3001, 16'h0004, 1'b1);
        sw = 9'h000;
        cyc(16'h7000, 16'h0000, 1'b0);
        cyc(16'h7000, 16'h0000, 1'b0);
        cyc(16'h7000, 16'h0000, 1'b0);
        sw = 9'h004;
        cyc(16'h7000, 16'h0000, 1'b0);
        cyc(16'h7000, 16'h0000, 1'b0);
        cyc(16'h3001, 16'h0004, 1'b1);
        cyc(16'h3001, 16'h0000, 1'b0);
        chk("edge_set_wins", din1, 16'h0004);
        cyc(16'h3000, 16'h01FF, 1'b1);
        chk("sw_wr_ignored", din1, 16'h0004);
        cyc(16'h3002, 16'h0000, 1'b0);
        chk("sw_off2", din1, 16'h0000);

        // one-shot timer, PRESCALE=1
        cyc(16'h4000, 16'h0003, 1'b1);
        cyc(16'h4002, 16'h0001, 1'b1);
        cyc(16'h4001, 16'h0000, 1'b0);
        chk("cnt3", din1, 16'h0003);
        cyc(16'h4001, 16'h0000, 1'b0);
        chk("cnt2", din1, 16'h0002);
        cyc(16'h4001, 16'h0000, 1'b0);
        chk("cnt1", din1, 16'h0001);
        chk("irq_early", {15'd0, irq1}, 16'h0000);
        cyc(16'h4001, 16'h0000, 1'b0);
        chk("cnt0", din1, 16'h0000);
        chk("irq_4cyc", {15'd0, irq1}, 16'h0001);
        cyc(16'h4002, 16'h0000, 1'b0);
        chk("en_cleared", din1, 16'h0000);
        cyc(16'h4001, 16'h0000, 1'b0);
        chk("cnt_stays0", din1, 16'h0000);
        cyc(16'h4003, 16'h0001, 1'b1);
        chk("irq_w1c", {15'd0, irq1}, 16'h0000);

        // auto-reload timer, PRESCALE=4
        cyc(16'h4002, 16'h0000, 1'b1);
        cyc(16'h4003, 16'h0001, 1'b1);
        cyc(16'h4000, 16'h0002, 1'b1);
        cyc(16'h4002, 16'h0003, 1'b1);
        for (int i = 0; i < 11; i++) cyc(16'h7000, 16'h0000, 1'b0);
        chk("p4_irq_11", {15'd0, irq4}, 16'h0000);
        cyc(16'h7000, 16'h0000, 1'b0);
        chk("p4_irq_12", {15'd0, irq4}, 16'h0001);
        cyc(16'h4001, 16'h0000, 1'b0);
        chk("p4_reload", din4, 16'h0002);
        cyc(16'h4003, 16'h0001, 1'b1);
        chk("p4_w1c", {15'd0, irq4}, 16'h0000);
        for (int i = 0; i < 9; i++) cyc(16'h7000, 16'h0000, 1'b0);
        chk("p4_irq_23", {15'd0, irq4}, 16'h0000);
        cyc(16'h4003, 16'h0001, 1'b1);
        chk("p4_set_wins", {15'd0, irq4}, 16'h0001);

        // reset in the middle of a count
        cyc(16'h1000, 16'h00AA, 1'b1);
        cyc(16'h4002, 16'h0000, 1'b1);
        cyc(16'h4000, 16'h0005, 1'b1);
        cyc(16'h4002, 16'h0001, 1'b1);
        rst  = 1'b1;
        addr = 16'h0000;
        w    = 1'b1;
        #1;
        chk("rst_mem_wren", {15'd0, mwren1}, 16'h0001);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_led", {7'd0, led1}, 16'h0000);
        chk("mid_rst_irq4", {15'd0, irq4}, 16'h0000);
        chk("mid_rst_din", din1, 16'h0000);
        cyc(16'h3001, 16'h0000, 1'b0);
        chk("mid_rst_edge", din1, 16'h0000);
        cyc(16'h3000, 16'h0000, 1'b0);
        chk("mid_rst_sync", din1, 16'h0000);
        cyc(16'h4000, 16'h0000, 1'b0);
        chk("mid_rst_load", din1, 16'h0000);
        cyc(16'h4001, 16'h0000, 1'b0);
        chk("mid_rst_count", din1, 16'h0000);
        cyc(16'h4002, 16'h0000, 1'b0);
        chk("mid_rst_ctrl", din1, 16'h0000);
        cyc(16'h4003, 16'h0000, 1'b0);
        chk("mid_rst_exp", din1, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mmio_hub.md
Name: mmio_hub

Overview:
Parametrised memory-mapped I/O hub between the processor bus (ADDR/DOUT/W/DIN) and its peripherals. It replaces ad-hoc top-level decoding with a single block containing:
- region decode and instruction-memory passthrough;
- a read-back LED register;
- synchronised switches with sticky rising-edge capture;
- a prescaled down-counting timer.

All reads return data exactly one cycle after the address, matching synchronous memory latency.

Parameters:
MEM_AW, 8, instruction-memory address width (mem_addr = ADDR[MEM_AW-1:0])
LED_W, 9, LED register width (1..16)
SW_W, 9, switch input width (1..16)
TIMER_W, 16, timer counter/load width (1..16)
PRESCALE, 1, clock cycles per timer decrement (>=1)

Ports:
Clock  in  1  system clock, all state on rising edge
Reset  in  1  synchronous, active-high reset
ADDR  in  16  processor address
DOUT  in  16  processor write data
W  in  1  processor write strobe
DIN  out  16  read data to processor, valid cycle after ADDR
mem_addr  out  MEM_AW  instruction-memory address
mem_wren  out  1  instruction-memory write enable
mem_q  in  16  instruction-memory sync read data
SW_in  in  SW_W  raw asynchronous switches
LED_out  out  LED_W  LED register
timer_irq  out  1  level = timer expired flag

Behaviour:
- One clock; reset is synchronous and active-high. Clock is Clock, reset is Reset.
- Region decode on ADDR[15:12]:
  - 0x0 = MEM
  - 0x1 = LED
  - 0x3 = SW
  - 0x4 = TMR
  - others = NONE
- Offset is ADDR[1:0]; higher offset bits are ignored within a region.
- MEM region:
  - mem_addr = ADDR[MEM_AW-1:0] (combinational, always driven).
  - mem_wren = W & MEM.
- Read path:
  - Register region select and peripheral read data at each edge.
  - Next cycle: DIN = mem_q if the registered select was MEM, else the registered peripheral data.
  - NONE reads return 0x0000.
  - Narrow fields are zero-extended to 16 bits.
  - Reset: registered select = NONE, DIN = 0.
- LED region (offset ignored):
  - Write: LED_out <= DOUT[LED_W-1:0].
  - Read returns LED_out.
  - Reset value 0.
- SW region:
  - Synchroniser: two flops on SW_in (s1, s2), plus a third flop s3 for edge detection. All reset to 0.
  - Offset 0: read s2 (synchronised level); writes ignored.
  - Offset 1: edge register E, read/write-1-to-clear. Each cycle E <= (E & ~clr) | (s2 & ~s3), where clr = DOUT[SW_W-1:0] on a write, else 0. A set and a clear of the same bit in the same cycle leaves the bit set.
  - Offsets 2 and 3 read 0.
- TMR region:
  - Offset 0 LOAD (RW): a write sets LOAD <= DOUT[TIMER_W-1:0] and COUNT <= the same value, and resets the prescaler.
  - Offset 1 COUNT: read-only.
  - Offset 2 CTRL (RW): bit0 EN, bit1 AUTO.
  - Offset 3 STATUS: bit0 EXP, write-1-to-clear.
  - Reset: LOAD = 0, COUNT = 0, CTRL = 0, EXP = 0, prescaler = 0.
- Prescaler: counts 0..PRESCALE-1 while EN=1; tick when it equals PRESCALE-1 (every cycle when PRESCALE=1). It holds its value while EN=0.
- On a tick:
  - If COUNT != 0: COUNT <= COUNT-1.
  - If COUNT == 0: EXP <= 1; then if AUTO, COUNT <= LOAD, else EN <= 0 (one-shot, COUNT stays 0).
- Expiry and clearing:
  - So with EN set, expiry occurs (LOAD+1)*PRESCALE cycles after EN rises.
  - Hardware setting EXP in the same cycle as a W1C clear: EXP ends set.
  - A LOAD write in the same cycle as a tick: the LOAD write wins and no decrement occurs.
  - A CTRL write in the same cycle as a one-shot expiry: the written CTRL value wins.
- timer_irq = EXP.
- Reset mid-operation (any cycle) returns every register above to its reset value on that edge. mem_wren remains combinational, so it follows W & MEM.

Test Plan:
- Reset asserted 2 cycles with W=1, ADDR=0x1000, DOUT=0x1FF -> LED_out=0, DIN=0, timer_irq=0 after release.
- Write 0x0155 to 0x1000, then read 0x1000 -> LED_out=0x155; DIN=0x0155 exactly one cycle after the read address. Read 0x0005 with mem_q=0xBEEF -> DIN=0xBEEF next cycle. Read 0x7000 -> DIN=0x0000.
- SW_in 0x000->0x005 -> 0x3000 reads 0x005 no earlier than the 3rd cycle; 0x3001 reads 0x005. Write 0x001 to 0x3001 -> reads 0x004. Clear bit 2 in the same cycle a new rising edge occurs on bit 2 -> bit 2 stays 1.
- PRESCALE=1, write LOAD=3 then CTRL=0x1 -> COUNT reads 3,2,1,0; EXP/timer_irq=1 4 cycles after EN; EN reads 0; COUNT stays 0. Write 0x1 to 0x4003 -> irq=0.
- PRESCALE=4, LOAD=2, CTRL=0x3 -> irq rises 12 cycles after EN; COUNT reloads to 2 and expires again 12 cycles later. W1C coincident with expiry -> EXP stays 1.
- Mid-count (COUNT=5) pulse Reset -> LOAD=COUNT=CTRL=EXP=0 next cycle; edge register and synchroniser flops cleared.
